cam_table_controller: RTL and testbench

- Learn/lookup engine for the switch's 16-entry MAC table.
- Sits directly upstream of the 16x48 two-port table SRAM. It drives that SRAM's RADDR, WADDR, WD and WEN, and consumes its RD.
- Per frame it accepts (src_mac, dst_mac, src_port), scans all entries, returns the destination port or flood, and learns or refreshes the source MAC.
- MACs live in SRAM; per-entry valid bits and port numbers live in flops inside this block.

---
 rtl/cam_table_pkg.sv | 23 ++
 rtl/cam_free_finder.sv | 22 ++
 rtl/cam_table_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_cam_table_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_table_pkg.sv
// Shared constants, FSM state type and MAC helpers for the MAC learn/lookup engine.
package cam_table_pkg;

  localparam int CAM_DEPTH = 16;
  localparam int CAM_AW    = 4;
  localparam int MAC_W     = 48;

  localparam logic [MAC_W-1:0] BROADCAST_MAC = {MAC_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_LEARN = 3'd3,
    ST_RESP  = 3'd4
  } cam_state_e;

  // The I/G bit is the LSB of the first octet on the wire.
  function automatic logic is_multicast(input logic [MAC_W-1:0] mac);
    return mac[40];
  endfunction

endpackage

// File: rtl/cam_free_finder.sv
// Priority encoder returning the lowest-index invalid table entry.
module cam_free_finder
  import cam_table_pkg::*;
(
  input  logic [CAM_DEPTH-1:0] valid_i,
  output logic                 free_found_o,
  output logic [CAM_AW-1:0]    free_idx_o
);

  // Walk downwards so the lowest free index is the last one written.
  always_comb begin
    free_found_o = 1'b0;
    free_idx_o   = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_found_o = 1'b1;
        free_idx_o   = CAM_AW'(i);
      end
    end
  end

endmodule

// File: rtl/cam_table_controller.sv
// Learn/lookup engine for a 16-entry MAC table held in an external two-port SRAM.
// Optional entry aging is enabled by defining CAM_TABLE_AGING_EN.
module cam_table_controller
  import cam_table_pkg::*;
#(
  parameter int PORT_W     = 2,
  parameter int RD_LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [47:0]       req_src_mac,
  input  logic [47:0]       req_dst_mac,
  input  logic [PORT_W-1:0] req_src_port,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_flood,
  output logic [PORT_W-1:0] resp_port,
  output logic [3:0]        ram_raddr,
  input  logic [47:0]       ram_rd,
  output logic [3:0]        ram_waddr,
  output logic [47:0]       ram_wd,
  output logic              ram_wen
);

  cam_state_e              state_q;
  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic                    resp_flood_q;
  logic [PORT_W-1:0]       resp_port_q;
  logic [CAM_AW-1:0]       raddr_q;
  logic [CAM_AW-1:0]       waddr_q;
  logic [MAC_W-1:0]        wd_q;
  logic                    wen_q;
  logic [CAM_AW-1:0]       victim_q;
  logic [CAM_DEPTH-1:0]    valid_q;
  logic [7:0]              drain_q;
  logic [RD_LATENCY-1:0]   tag_q;
  logic [CAM_AW-1:0]       tidx_q [RD_LATENCY];
  logic                    src_hit_q;
  logic                    dst_hit_q;
  logic [CAM_AW-1:0]       src_idx_q;
  logic [CAM_AW-1:0]       dst_idx_q;
  logic [MAC_W-1:0]        src_mac_q;
  logic [MAC_W-1:0]        dst_mac_q;
  logic [PORT_W-1:0]       src_port_q;
  logic [PORT_W-1:0]       port_q [CAM_DEPTH];

  logic                    accept;
  logic [CAM_AW-1:0]       rd_idx;
  logic                    rd_live;
  logic                    src_hit_d;
  logic                    dst_hit_d;
  logic [CAM_AW-1:0]       src_idx_d;
  logic [CAM_AW-1:0]       dst_idx_d;
  logic                    learn_d;
  logic                    free_found;
  logic [CAM_AW-1:0]       free_idx;

`ifdef CAM_TABLE_AGING_EN
  logic [23:0]             tick_q;
  logic [CAM_DEPTH-1:0]    age_q;
  logic                    age_pend_q;
  logic                    age_wrap;
  logic                    age_inv;
`endif

  cam_free_finder u_free_finder (
    .valid_i      (valid_q),
    .free_found_o (free_found),
    .free_idx_o   (free_idx)
  );

  assign accept = (state_q == ST_IDLE) && req_valid && req_ready_q;

  // Each returned word carries the index it was read from, RD_LATENCY cycles late.
  assign rd_idx    = tidx_q[RD_LATENCY-1];
  assign rd_live   = tag_q[RD_LATENCY-1] && valid_q[rd_idx];
  assign src_hit_d = src_hit_q || (rd_live && (ram_rd == src_mac_q));
  assign dst_hit_d = dst_hit_q || (rd_live && (ram_rd == dst_mac_q));
  assign src_idx_d = src_hit_q ? src_idx_q : rd_idx;
  assign dst_idx_d = dst_hit_q ? dst_idx_q : rd_idx;
  assign learn_d   = !src_hit_d && !is_multicast(src_mac_q) && (src_mac_q != BROADCAST_MAC);

`ifdef CAM_TABLE_AGING_EN
  assign age_wrap = &tick_q;
  assign age_inv  = (age_wrap || age_pend_q) && (state_q != ST_LEARN);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_flood_q <= 1'b0;
      resp_port_q  <= '0;
      raddr_q      <= '0;
      waddr_q      <= '0;
      wd_q         <= '0;
      wen_q        <= 1'b0;
      victim_q     <= '0;
      valid_q      <= '0;
      drain_q      <= '0;
      tag_q        <= '0;
      src_hit_q    <= 1'b0;
      dst_hit_q    <= 1'b0;
      src_idx_q    <= '0;
      dst_idx_q    <= '0;
`ifdef CAM_TABLE_AGING_EN
      tick_q       <= '0;
      age_q        <= '0;
      age_pend_q   <= 1'b0;
`endif
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) tag_q[i] <= tag_q[i-1];
      tag_q[0] <= (state_q == ST_SCAN);

      if (tag_q[RD_LATENCY-1]) begin
        src_hit_q <= src_hit_d;
        dst_hit_q <= dst_hit_d;
        src_idx_q <= src_idx_d;
        dst_idx_q <= dst_idx_d;
      end

`ifdef CAM_TABLE_AGING_EN
      tick_q     <= tick_q + 1'b1;
      age_pend_q <= age_wrap && (state_q == ST_LEARN);
      if (age_inv) begin
        valid_q <= valid_q & age_q;
        age_q   <= '0;
      end
`endif

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            raddr_q     <= '0;
            src_hit_q   <= 1'b0;
            dst_hit_q   <= 1'b0;
            state_q     <= ST_SCAN;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (raddr_q == CAM_AW'(CAM_DEPTH - 1)) begin
            raddr_q <= '0;
            drain_q <= '0;
            state_q <= ST_DRAIN;
          end else begin
            raddr_q <= raddr_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_q == 8'(RD_LATENCY - 1)) begin
            state_q <= ST_LEARN;
            // Decide on the last word's compare so the write lands in LEARN.
            if (learn_d) begin
              wen_q <= 1'b1;
              wd_q  <= src_mac_q;
              if (free_found) begin
                waddr_q <= free_idx;
              end else begin
                waddr_q  <= victim_q;
                victim_q <= victim_q + 1'b1;
              end
            end
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        ST_LEARN: begin
          wen_q <= 1'b0;
          if (wen_q) valid_q[waddr_q] <= 1'b1;
`ifdef CAM_TABLE_AGING_EN
          if (src_hit_q) age_q[src_idx_q] <= 1'b1;
          if (wen_q)     age_q[waddr_q]   <= 1'b1;
`endif
          resp_valid_q <= 1'b1;
          resp_flood_q <= !dst_hit_q || (dst_mac_q == BROADCAST_MAC);
          resp_port_q  <= dst_hit_q ? port_q[dst_idx_q] : '0;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_flood_q <= 1'b0;
            resp_port_q  <= '0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request fields, read-index pipeline and port table carry no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      src_mac_q  <= req_src_mac;
      dst_mac_q  <= req_dst_mac;
      src_port_q <= req_src_port;
    end
    for (int i = RD_LATENCY - 1; i > 0; i--) tidx_q[i] <= tidx_q[i-1];
    tidx_q[0] <= raddr_q;
    if (state_q == ST_LEARN) begin
      if (src_hit_q && (port_q[src_idx_q] != src_port_q)) begin
        port_q[src_idx_q] <= src_port_q;
      end else if (wen_q) begin
        port_q[waddr_q] <= src_port_q;
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_flood = resp_flood_q;
  assign resp_port  = resp_port_q;
  assign ram_raddr  = raddr_q;
  assign ram_waddr  = waddr_q;
  assign ram_wd     = wd_q;
  assign ram_wen    = wen_q;

endmodule

// File: tb/tb_cam_table_controller.sv
// Bench for cam_table_controller: SRAM model, table reference model, directed and random requests.
module tb_cam_table_controller;

  localparam int PORT_W = 2;
  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

  logic              CLK = 1'b0;
  logic              RST;
  logic              req_valid;
  logic              req_ready;
  logic [47:0]       req_src_mac;
  logic [47:0]       req_dst_mac;
  logic [PORT_W-1:0] req_src_port;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_flood;
  logic [PORT_W-1:0] resp_port;
  logic [3:0]        ram_raddr;
  logic [47:0]       ram_rd;
  logic [3:0]        ram_waddr;
  logic [47:0]       ram_wd;
  logic              ram_wen;

  cam_table_controller #(.PORT_W(PORT_W), .RD_LATENCY(2)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_src_mac  (req_src_mac),
    .req_dst_mac  (req_dst_mac),
    .req_src_port (req_src_port),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_flood   (resp_flood),
    .resp_port    (resp_port),
    .ram_raddr    (ram_raddr),
    .ram_rd       (ram_rd),
    .ram_waddr    (ram_waddr),
    .ram_wd       (ram_wd),
    .ram_wen      (ram_wen)
  );

  always #5 CLK = ~CLK;

  // Two-cycle registered-read SRAM.
  logic [47:0] mem [16];
  logic [47:0] rd1;
  always @(posedge CLK) begin
    if (ram_wen) mem[ram_waddr] <= ram_wd;
    rd1    <= mem[ram_raddr];
    ram_rd <= rd1;
  end

  // Reference table contents.
  bit          m_valid [16];
  logic [47:0] m_mac   [16];
  logic [1:0]  m_port  [16];
  int          m_victim;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
    m_victim = 0;
  endtask

  function automatic logic [47:0] mac_of(input int k);
    logic [7:0] lo;
    lo = 8'(k);
    return {8'h02, 32'h0, lo};
  endfunction

  task automatic check_all_zero(input string tag);
    chk(tag, {req_ready, resp_valid, resp_flood, resp_port, ram_raddr, ram_waddr, ram_wd, ram_wen}, 64'h0);
  endtask

  task automatic run_req(input logic [47:0] src, input logic [47:0] dst,
                         input logic [1:0] sp, input int hold);
    int s_idx, d_idx, exp_wa, lat, wen_cnt, n;
    bit exp_flood, exp_wr;
    logic [1:0]  exp_port;
    logic [3:0]  wa;
    logic [47:0] wd;
    s_idx = -1;
    d_idx = -1;
    for (int i = 0; i < 16; i++) begin
      if (m_valid[i] && m_mac[i] == src && s_idx < 0) s_idx = i;
      if (m_valid[i] && m_mac[i] == dst && d_idx < 0) d_idx = i;
    end
    exp_flood = (d_idx < 0) || (dst == ONES);
    exp_port  = (d_idx >= 0) ? m_port[d_idx] : 2'd0;
    exp_wr    = 0;
    exp_wa    = 0;
    if (s_idx >= 0) begin
      m_port[s_idx] = sp;
    end else if (!src[40] && src != ONES) begin
      exp_wr = 1;
      exp_wa = -1;
      for (int i = 0; i < 16; i++) if (!m_valid[i] && exp_wa < 0) exp_wa = i;
      if (exp_wa < 0) begin
        exp_wa   = m_victim;
        m_victim = (m_victim + 1) % 16;
      end
      m_valid[exp_wa] = 1;
      m_mac[exp_wa]   = src;
      m_port[exp_wa]  = sp;
    end

    @(negedge CLK);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("req_ready", req_ready, 1);
    req_valid    = 1;
    req_src_mac  = src;
    req_dst_mac  = dst;
    req_src_port = sp;
    @(posedge CLK);
    #1 req_valid = 0;

    lat = 0;
    wen_cnt = 0;
    wa = '0;
    wd = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      if (ram_wen) begin
        wen_cnt++;
        wa = ram_waddr;
        wd = ram_wd;
      end
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    chk("latency", lat, 20);
    chk("flood", resp_flood, exp_flood);
    chk("port", resp_port, exp_port);
    chk("wen_count", wen_cnt, exp_wr);
    if (exp_wr) begin
      chk("waddr", wa, exp_wa);
      chk("wdata", wd, src);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk("resp_hold", {resp_valid, resp_flood, resp_port}, {1'b1, exp_flood, exp_port});
    end
    resp_ready = 1;
    @(posedge CLK);
    #1 resp_ready = 0;
    chk("resp_drop", resp_valid, 0);
  endtask

  initial begin
    int n;
    logic [47:0] s, d;
    RST          = 1;
    req_valid    = 0;
    req_src_mac  = '0;
    req_dst_mac  = '0;
    req_src_port = '0;
    resp_ready   = 0;
    model_reset();
    repeat (3) @(negedge CLK);
    check_all_zero("reset_outputs");
    RST = 0;

    // Empty table: flood and learn at 0; then reverse direction hits.
    run_req(mac_of(1), mac_of(2), 2'd1, 1);
    run_req(mac_of(2), mac_of(1), 2'd3, 0);
    // Port move without an SRAM write, then confirm the new port.
    run_req(mac_of(1), mac_of(2), 2'd2, 0);
    run_req(mac_of(2), mac_of(1), 2'd3, 0);

    // Fill remaining entries, then evict via the victim pointer.
    for (int k = 3; k <= 16; k++) run_req(mac_of(k), mac_of(k - 1), 2'(k), 0);
    run_req(mac_of(17), mac_of(16), 2'd1, 0);
    run_req(mac_of(18), mac_of(1), 2'd2, 0);
    run_req(mac_of(17), mac_of(18), 2'd0, 0);

    // Multicast source never learns; broadcast destination always floods.
    run_req(48'h01_00_5E_00_00_33, ONES, 2'd1, 2);
    run_req(ONES, mac_of(5), 2'd3, 0);

    // Reset while scanning aborts the operation.
    @(negedge CLK);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    req_valid    = 1;
    req_src_mac  = mac_of(40);
    req_dst_mac  = mac_of(3);
    req_src_port = 2'd2;
    @(posedge CLK);
    #1 req_valid = 0;
    repeat (5) @(negedge CLK);
    chk("scan_raddr_nonzero", ram_raddr != 4'd0, 1);
    RST = 1;
    #1;
    check_all_zero("mid_scan_reset");
    @(negedge CLK);
    check_all_zero("mid_scan_reset_hold");
    RST = 0;
    model_reset();
    run_req(mac_of(1), mac_of(2), 2'd1, 5);
    run_req(mac_of(3), mac_of(1), 2'd2, 0);

    // Random traffic over a small MAC pool so hits, misses and evictions mix.
    for (int r = 0; r < 60; r++) begin
      s = mac_of($urandom_range(1, 22));
      d = mac_of($urandom_range(1, 22));
      if ($urandom_range(0, 7) == 0) s[40] = 1'b1;
      if ($urandom_range(0, 7) == 0) d = ONES;
      run_req(s, d, 2'($urandom_range(0, 3)), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
